// File: rtl/debug_pkg.sv
// Shared definitions for the ASCII debug protocol.
//   rsp_kind_t      : response kind passed from the register side to the encoder
//   CH_*            : ASCII framing characters
//   nibble_to_ascii : 4-bit value -> upper-case hex character
//   ascii_to_nibble : hex character (either case) -> {valid, nibble}, used by the parser
package debug_pkg;

   typedef enum logic [1:0] {
      RSP_READ = 2'd0,
      RSP_WACK = 2'd1,
      RSP_ERR  = 2'd2
   } rsp_kind_t;

   localparam logic [7:0] CH_NL     = 8'h0A;
   localparam logic [7:0] CH_PROMPT = 8'h3E;
   localparam logic [7:0] CH_EQ     = 8'h3D;
   localparam logic [7:0] CH_O      = 8'h4F;
   localparam logic [7:0] CH_K      = 8'h4B;
   localparam logic [7:0] CH_ERR    = 8'h3F;

   function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
      if (nib < 4'd10) return 8'h30 + {4'h0, nib};
      else             return 8'h37 + {4'h0, nib};
   endfunction

   // Bit 4 is the valid flag; bits 3:0 the decoded value (0 when invalid).
   function automatic logic [4:0] ascii_to_nibble(input logic [7:0] ch);
      logic [7:0] v;
      if (ch >= 8'h30 && ch <= 8'h39) begin
         v = ch - 8'h30;
         return {1'b1, v[3:0]};
      end else if (ch >= 8'h41 && ch <= 8'h46) begin
         v = ch - 8'h37;
         return {1'b1, v[3:0]};
      end else if (ch >= 8'h61 && ch <= 8'h66) begin
         v = ch - 8'h57;
         return {1'b1, v[3:0]};
      end
      return 5'h00;
   endfunction

endpackage

// File: rtl/response_encoder.sv
// response_encoder: serialises one decoded response per valid/ready handshake
// into ASCII characters for the UART transmitter.
//   clk, rst_n        clock, async active-low reset
//   rsp_valid/ready   request handshake (ready only in IDLE)
//   rsp_kind/addr/data response contents, latched on acceptance
//   tx_data_o/tx_start character and one-cycle load pulse to uart_tx
//   busy              uart_tx busy
//   frame_active      high from acceptance until the last character completes
//
// state | meaning
// IDLE  | waiting for a request, rsp_ready high
// LOAD  | register the character at idx into tx_data_o
// SEND  | pulse tx_start once busy is low
// ACK   | one cycle for uart_tx to raise busy
// WAIT  | wait for busy to fall, then next char or IDLE
module response_encoder
   import debug_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int REG_ADDR_BITS = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rsp_valid,
   output logic                     rsp_ready,
   input  logic [1:0]               rsp_kind,
   input  logic [REG_ADDR_BITS-1:0] rsp_addr,
   input  logic [DATA_WIDTH-1:0]    rsp_data,
   output logic [7:0]               tx_data_o,
   output logic                     tx_start,
   input  logic                     busy,
   output logic                     frame_active
);

   localparam int AN        = REG_ADDR_BITS / 4;
   localparam int DN        = DATA_WIDTH / 4;
   localparam int FRAME_MAX = 3 + AN + DN;
   localparam int IDX_W     = $clog2(FRAME_MAX);

   localparam logic [IDX_W-1:0] LAST_READ = IDX_W'(FRAME_MAX - 1);
   localparam logic [IDX_W-1:0] LAST_WACK = IDX_W'(3);
   localparam logic [IDX_W-1:0] LAST_ERR  = IDX_W'(2);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_SEND = 3'd2;
   localparam logic [2:0] S_ACK  = 3'd3;
   localparam logic [2:0] S_WAIT = 3'd4;

   logic [2:0]               state_q;
   logic [IDX_W-1:0]         idx_q;
   rsp_kind_t                kind_q;
   logic [REG_ADDR_BITS-1:0] addr_q;
   logic [DATA_WIDTH-1:0]    data_q;
   logic [7:0]               tx_data_q;
   logic [IDX_W-1:0]         last_idx;
   logic [7:0]               char_cur;
   logic [REG_ADDR_BITS-1:0] addr_sh;
   logic [DATA_WIDTH-1:0]    data_sh;

   assign rsp_ready    = (state_q == S_IDLE);
   assign frame_active = (state_q != S_IDLE);
   assign tx_start     = (state_q == S_SEND) && !busy;
   assign tx_data_o    = tx_data_q;

   always_comb begin
      case (kind_q)
         RSP_READ: last_idx = LAST_READ;
         RSP_WACK: last_idx = LAST_WACK;
         default:  last_idx = LAST_ERR;
      endcase
   end

   // Character at idx_q; hex digits are picked by shifting the wanted nibble down to bit 0.
   always_comb begin
      char_cur = CH_NL;
      addr_sh  = '0;
      data_sh  = '0;
      if (idx_q == IDX_W'(0)) begin
         char_cur = CH_NL;
      end else if (idx_q == IDX_W'(1)) begin
         char_cur = CH_PROMPT;
      end else begin
         case (kind_q)
            RSP_READ: begin
               if (int'(idx_q) < 2 + AN) begin
                  addr_sh  = addr_q >> (4 * (AN + 1 - int'(idx_q)));
                  char_cur = nibble_to_ascii(addr_sh[3:0]);
               end else if (int'(idx_q) == 2 + AN) begin
                  char_cur = CH_EQ;
               end else begin
                  data_sh  = data_q >> (4 * (AN + DN + 2 - int'(idx_q)));
                  char_cur = nibble_to_ascii(data_sh[3:0]);
               end
            end
            RSP_WACK: char_cur = (idx_q == IDX_W'(2)) ? CH_O : CH_K;
            default:  char_cur = CH_ERR;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         kind_q    <= RSP_READ;
         addr_q    <= '0;
         data_q    <= '0;
         tx_data_q <= 8'h00;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (rsp_valid) begin
                  kind_q  <= (rsp_kind == 2'd3) ? RSP_ERR : rsp_kind_t'(rsp_kind);
                  addr_q  <= rsp_addr;
                  data_q  <= rsp_data;
                  idx_q   <= '0;
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               tx_data_q <= char_cur;
               state_q   <= S_SEND;
            end
            S_SEND: begin
               if (!busy) state_q <= S_ACK;
            end
            S_ACK: begin
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (!busy) begin
                  if (idx_q == last_idx) begin
                     state_q <= S_IDLE;
                  end else begin
                     idx_q   <= idx_q + 1'b1;
                     state_q <= S_LOAD;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_response_encoder.sv
module tb_response_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [1:0] rsp_kind;
   logic [7:0] rsp_addr;
   logic [7:0] rsp_data;
   logic [7:0] tx_data_o;
   logic       tx_start;
   logic       busy;
   logic       frame_active;

   logic       busy_force = 1'b0;
   int         ucnt = 0;

   int         n_checks = 0;
   int         n_fail = 0;
   logic [7:0] cap[$];

   logic       prev_start = 1'b0;
   logic [7:0] prev_data = 8'h00;

   response_encoder #(.DATA_WIDTH(8), .REG_ADDR_BITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_kind(rsp_kind), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
      .tx_data_o(tx_data_o), .tx_start(tx_start), .busy(busy),
      .frame_active(frame_active)
   );

   always #5 clk = ~clk;

   // UART busy model: busy rises the cycle after tx_start and lasts 10 cycles.
   always @(posedge clk) begin
      if (tx_start)      ucnt <= 10;
      else if (ucnt != 0) ucnt <= ucnt - 1;
   end
   assign busy = busy_force | (ucnt != 0);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Character capture plus the always-on protocol checks.
   always @(negedge clk) begin
      if (tx_start) begin
         cap.push_back(tx_data_o);
         check("start_while_busy", 64'(tx_start && busy), 64'd0);
      end
      if (prev_start) check("tx_data_stable_ack", 64'(tx_data_o), 64'(prev_data));
      prev_start <= tx_start;
      prev_data  <= tx_data_o;
   end

   typedef struct {
      logic [1:0]  kind;
      logic [7:0]  addr;
      logic [7:0]  data;
      int          len;
      logic [55:0] exp;   // characters MS-aligned, first char in bits 55:48
   } vec_t;

   vec_t vecs[6];

   task automatic issue(input logic [1:0] k, input logic [7:0] a, input logic [7:0] d);
      int n;
      @(negedge clk);
      rsp_valid = 1'b1; rsp_kind = k; rsp_addr = a; rsp_data = d;
      n = 0;
      while (!rsp_ready && n < 2000) begin @(negedge clk); n++; end
      check("accept_timeout", 64'(n < 2000), 64'd1);
      @(negedge clk);
      rsp_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (frame_active && n < 2000) begin @(negedge clk); n++; end
      check("frame_timeout", 64'(n < 2000), 64'd1);
   endtask

   task automatic check_frame(input string name, input int len, input logic [55:0] exp);
      check({name, "_len"}, 64'(cap.size()), 64'(len));
      for (int i = 0; i < len; i++) begin
         if (i < cap.size())
            check($sformatf("%s_char%0d", name, i), 64'(cap[i]), 64'(exp[55-8*i -: 8]));
      end
   endtask

   initial begin
      int n;
      int bad;
      vecs[0] = '{2'd0, 8'h1F, 8'hA5, 7, 56'h0A3E31463D4135};
      vecs[1] = '{2'd1, 8'h55, 8'h66, 4, 56'h0A3E4F4B000000};
      vecs[2] = '{2'd2, 8'h12, 8'h34, 3, 56'h0A3E3F00000000};
      vecs[3] = '{2'd3, 8'hFF, 8'hFF, 3, 56'h0A3E3F00000000};
      vecs[4] = '{2'd0, 8'h00, 8'hFF, 7, 56'h0A3E30303D4646};
      vecs[5] = '{2'd0, 8'hC9, 8'h3B, 7, 56'h0A3E43393D3342};

      rst_n = 1'b0; rsp_valid = 1'b0; rsp_kind = 2'd0; rsp_addr = 8'h00; rsp_data = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_tx_data", 64'(tx_data_o), 64'h00);
      check("rst_tx_start", 64'(tx_start), 64'd0);
      check("rst_frame_active", 64'(frame_active), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", 64'(rsp_ready), 64'd1);

      // Latency: accept at a posedge, LOAD the next cycle, tx_start in the one after.
      cap.delete();
      rsp_valid = 1'b1; rsp_kind = 2'd0; rsp_addr = 8'h1F; rsp_data = 8'hA5;
      @(negedge clk);
      rsp_valid = 1'b0;
      check("lat_ready_low", 64'(rsp_ready), 64'd0);
      check("lat_frame_active", 64'(frame_active), 64'd1);
      check("lat_load_no_start", 64'(tx_start), 64'd0);
      @(negedge clk);
      check("lat_send_start", 64'(tx_start), 64'd1);
      check("lat_send_char", 64'(tx_data_o), 64'h0A);
      wait_idle();
      check_frame("lat_read", 7, 56'h0A3E31463D4135);

      for (int v = 0; v < 6; v++) begin
         cap.delete();
         issue(vecs[v].kind, vecs[v].addr, vecs[v].data);
         wait_idle();
         check_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].exp);
      end

      // Back-to-back WACK then ERR with rsp_valid held throughout.
      cap.delete();
      @(negedge clk);
      rsp_valid = 1'b1; rsp_kind = 2'd1; rsp_addr = 8'h00; rsp_data = 8'h00;
      @(negedge clk);
      rsp_kind = 2'd2;
      bad = 0; n = 0;
      while (frame_active && n < 2000) begin
         if (rsp_ready) bad++;
         @(negedge clk); n++;
      end
      check("b2b_timeout", 64'(n < 2000), 64'd1);
      check("b2b_ready_low_in_frame", 64'(bad), 64'd0);
      check("b2b_ready_in_idle", 64'(rsp_ready), 64'd1);
      @(negedge clk);
      rsp_valid = 1'b0;
      check("b2b_second_accepted", 64'(frame_active), 64'd1);
      wait_idle();
      check_frame("b2b", 7, 56'h0A3E4F4B0A3E3F);

      // busy already high at acceptance: hold in SEND with the first char stable.
      busy_force = 1'b1;
      cap.delete();
      issue(2'd1, 8'h00, 8'h00);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx_start || tx_data_o !== 8'h0A) bad++;
      end
      check("busy_hold_cycles", 64'(bad), 64'd0);
      check("busy_hold_no_chars", 64'(cap.size()), 64'd0);
      busy_force = 1'b0;
      wait_idle();
      check_frame("busy_hold", 4, 56'h0A3E4F4B000000);

      // Reset after the 3rd character of a READ.
      cap.delete();
      issue(2'd0, 8'h1F, 8'hA5);
      n = 0;
      while (cap.size() < 3 && n < 2000) begin @(negedge clk); n++; end
      check("rst_mid_timeout", 64'(n < 2000), 64'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_tx_data", 64'(tx_data_o), 64'h00);
      check("rst_mid_tx_start", 64'(tx_start), 64'd0);
      check("rst_mid_frame_active", 64'(frame_active), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_ready", 64'(rsp_ready), 64'd1);
      check("rst_mid_partial", 64'(cap.size()), 64'd3);
      cap.delete();
      issue(2'd0, 8'h2B, 8'h70);
      wait_idle();
      check_frame("after_rst", 7, 56'h0A3E32423D3730);

      // Live rsp_kind and rsp_valid churn during a frame must not affect it.
      cap.delete();
      issue(2'd0, 8'h1F, 8'hA5);
      n = 0;
      while (cap.size() < 5 && n < 2000) begin
         @(negedge clk);
         rsp_valid = n[0];
         rsp_kind  = 2'(n + 1);
         n++;
      end
      rsp_valid = 1'b0;
      check("churn_timeout", 64'(n < 2000), 64'd1);
      wait_idle();
      check_frame("churn", 7, 56'h0A3E31463D4135);
      repeat (20) @(negedge clk);
      check("churn_no_extra_accept", 64'(frame_active), 64'd0);
      check("churn_no_extra_chars", 64'(cap.size()), 64'd7);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
